// File: rtl/hazard_stall_unit.sv
// Load-use stall and ID-stage operand forwarding selects for the 5-stage pipeline.
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
module hazard_stall_unit #(
  parameter int unsigned RN_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RN_W-1:0]  id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_squash,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  logic [RN_W-1:0] ex_rn_q, ex_rn_d, mem_rn_q, mem_rn_d;
  logic            ex_wreg_q, ex_wreg_d, mem_wreg_q, mem_wreg_d;
  logic            ex_m2reg_q, ex_m2reg_d, mem_m2reg_q, mem_m2reg_d;

  logic hit_rs, hit_rt;
  logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt;

  // A source only matches when it is actually read and is not $0.
  assign hit_rs = id_use_rs && (id_rs != RN_W'(0));
  assign hit_rt = id_use_rt && (id_rt != RN_W'(0));

  assign ex_match_rs  = hit_rs && ex_wreg_q  && (id_rs == ex_rn_q);
  assign ex_match_rt  = hit_rt && ex_wreg_q  && (id_rt == ex_rn_q);
  assign mem_match_rs = hit_rs && mem_wreg_q && (id_rs == mem_rn_q);
  assign mem_match_rt = hit_rt && mem_wreg_q && (id_rt == mem_rn_q);

  assign stall  = ex_m2reg_q && (ex_match_rs || ex_match_rt);
  assign bubble = stall;

  // EX (youngest) wins; an EX load match stalls and leaves the select at regfile.
  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m,
                                         input logic ex_ld, input logic mem_ld);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_m)       sel = ex_ld  ? FWD_RF     : FWD_EX_ALU;
    else if (mem_m) sel = mem_ld ? FWD_MEM_LD : FWD_MEM_ALU;
    return sel;
  endfunction

  assign fwda = fwd_sel(ex_match_rs, mem_match_rs, ex_m2reg_q, mem_m2reg_q);
  assign fwdb = fwd_sel(ex_match_rt, mem_match_rt, ex_m2reg_q, mem_m2reg_q);

  // Shadow pipeline advance; stalled or squashed ID enters EX as a bubble.
  always_comb begin
    mem_rn_d    = ex_rn_q;
    mem_wreg_d  = ex_wreg_q;
    mem_m2reg_d = ex_m2reg_q;
    ex_rn_d     = id_rn;
    ex_wreg_d   = id_wreg;
    ex_m2reg_d  = id_m2reg;
    if (stall || id_squash) begin
      ex_rn_d    = RN_W'(0);
      ex_wreg_d  = 1'b0;
      ex_m2reg_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_rn_q     <= RN_W'(0);
      ex_wreg_q   <= 1'b0;
      ex_m2reg_q  <= 1'b0;
      mem_rn_q    <= RN_W'(0);
      mem_wreg_q  <= 1'b0;
      mem_m2reg_q <= 1'b0;
    end else begin
      ex_rn_q     <= ex_rn_d;
      ex_wreg_q   <= ex_wreg_d;
      ex_m2reg_q  <= ex_m2reg_d;
      mem_rn_q    <= mem_rn_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_m2reg_q <= mem_m2reg_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of stall cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= CNT_W'(0);
    else       cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = CNT_W'(0);
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of the IF/ID `stall` signal and the ID-stage operand-forwarding selects for the 5-stage pipelined CPU.
- Holds shadow copies of the destination-register info for instructions in EX and MEM.
- Detects load-use hazards and raises `stall` (freezes PC and IF/ID) plus `bubble` (zeroes ID/EX controls) for exactly one cycle.
- Drives forwarding mux selects for the rs/rt operands decoded in ID.

Parameters:
- RN_W, 5, register-number width.
- CNT_W, 16, width of stall performance counter; used only with the optional feature.

Ports:
- clk  input  1  clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- id_rs  input  RN_W  rs field of instruction in ID.
- id_rt  input  RN_W  rt field of instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_rn  input  RN_W  destination register of ID instruction.
- id_wreg  input  1  ID instruction writes the register file.
- id_m2reg  input  1  ID instruction is a load.
- id_squash  input  1  ID instruction is killed (taken branch); enters EX as a bubble.
- stall  output  1  to IF_ID stall and PC hold.
- bubble  output  1  to ID/EX: clear wreg/m2reg/wmem.
- fwda  output  2  rs select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- fwdb  output  2  rt select, same encoding.
- stall_count  output  CNT_W  total stall cycles.

Behaviour:
- Internal shadow state: ex_rn/ex_wreg/ex_m2reg and mem_rn/mem_wreg/mem_m2reg. On clrn=0 all are 0. Outputs are combinational from shadow state plus ID inputs, so all outputs are 0 during reset.
- Each posedge:
  - mem_* <= ex_*.
  - If stall or id_squash: ex_* <= 0 (bubble). Otherwise ex_* <= id_rn, id_wreg, id_m2reg.
- A destination with rn==0 never matches (register 0 hardwired). The hit term for a source s is use_s & s!=0.
- Load-use: stall = ex_wreg & ex_m2reg & ((hit_rs & id_rs==ex_rn) | (hit_rt & id_rt==ex_rn)). bubble = stall.
- Stall is always exactly one cycle per load-use. Next cycle the load sits in MEM and forwards via 11.
- Forwarding for fwda (fwdb identical with rt), first match wins:
  - EX match, non-load: 01.
  - Else MEM match, non-load: 10.
  - Else MEM match, load: 11.
  - Else 00.
  - An EX match on a load yields stall, with fwda=00 that cycle (ignored, ID is frozen).
- EX has priority over MEM when both target the same register (youngest value wins).
- No WB forwarding: the register file writes in the first half-cycle and reads in the second.
- Simultaneous stall and id_squash: squash wins for EX entry (bubble either way). stall still asserts this cycle.
- Reset mid-stall: shadow state clears, stall drops immediately (async).

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_count increments by 1 each posedge with stall=1.
  - Saturates at all-ones.
  - Clears on clrn=0.
- Undefined: no counter register; stall_count is tied to 0.

Test Plan:
- Reset: clrn=0 with arbitrary inputs -> stall=0, bubble=0, fwda=fwdb=00, stall_count=0.
- Load-use: lw $2 (id_rn=2, wreg=1, m2reg=1), then add reading rs=2 -> cycle 2: stall=1, bubble=1. Cycle 3: stall=0, fwda=11.
- ALU chain: add $3 then sub with rs=3, rt=3 -> fwda=fwdb=01. Following instruction reading $3 -> 10. No stall.
- Priority: add $4, add $4, then inst reading rs=4 -> fwda=01 (EX), not 10.
- Register 0: lw $0 then add reading rs=0 -> stall=0, fwda=00.
- Squash + perf: lw $5 with id_squash=1, then add reading $5 -> no stall. With HAZARD_PERF_EN, 3 load-use hazards -> stall_count=3.
